// File: rtl/order_dispatcher.sv
// order_dispatcher: buffers decoded order commands (ADD/CANCEL/EXECUTE) in a
// small FIFO and hands them to the order-book wrapper one at a time using a
// start pulse / busy handshake. Malformed commands are discarded at pop time.
// Optional build macro DISPATCH_STATS_EN: when defined, the dispatch, drop and
// timeout counters are built; when undefined those outputs read zero.
module order_dispatcher #(
   parameter int STOCK_W      = 2,
   parameter int NUM_STOCKS   = 2,
   parameter int ORDER_W      = 32,
   parameter int QTY_W        = 8,
   parameter int OID_W        = 8,
   parameter int DEPTH        = 8,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_request,
   input  logic [STOCK_W-1:0]         in_stock,
   input  logic [ORDER_W-1:0]         in_order,
   input  logic [QTY_W-1:0]           in_qty,
   input  logic [OID_W-1:0]           in_order_id,
   output logic                       ob_start,
   output logic [2:0]                 ob_request,
   output logic [STOCK_W-1:0]         ob_stock,
   output logic [ORDER_W-1:0]         ob_order,
   output logic [QTY_W-1:0]           ob_qty,
   output logic [OID_W-1:0]           ob_order_id,
   input  logic                       ob_busy,
   output logic                       done_pulse,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic [15:0]                dispatch_count,
   output logic [15:0]                drop_count,
   output logic [7:0]                 timeout_count
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int TW      = $clog2(BUSY_TIMEOUT + 1);
   localparam int ENTRY_W = 3 + STOCK_W + ORDER_W + QTY_W + OID_W;

   localparam logic [LW-1:0]      LEVEL_ZERO  = {LW{1'b0}};
   localparam logic [LW-1:0]      LEVEL_ONE   = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0]      LEVEL_FULL  = LW'(DEPTH);
   localparam logic [AW-1:0]      PTR_ONE     = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0]      TIMER_ONE   = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0]      TIMER_LIMIT = TW'(BUSY_TIMEOUT);
   localparam logic [STOCK_W:0]   STOCK_LIMIT = (STOCK_W + 1)'(NUM_STOCKS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   // A command is legal when its opcode is ADD/CANCEL/EXECUTE and its stock exists.
   function automatic logic cmd_ok(input logic [2:0] req, input logic [STOCK_W-1:0] stk);
      logic req_ok;
      req_ok = (req == 3'd1) || (req == 3'd2) || (req == 3'd3);
      return req_ok && ({1'b0, stk} < STOCK_LIMIT);
   endfunction

   state_t               state_r;
   state_t               state_next_s;
   logic [ENTRY_W-1:0]   mem_r [DEPTH];
   logic [AW-1:0]        wr_ptr_r;
   logic [AW-1:0]        rd_ptr_r;
   logic [LW-1:0]        level_r;
   logic [LW-1:0]        level_next_s;
   logic                 in_ready_r;
   logic                 push_s;
   logic [ENTRY_W-1:0]   head_s;
   logic [2:0]           head_req_s;
   logic [STOCK_W-1:0]   head_stock_s;
   logic [ORDER_W-1:0]   head_order_s;
   logic [QTY_W-1:0]     head_qty_s;
   logic [OID_W-1:0]     head_oid_s;
   logic                 head_ok_s;
   logic                 latch_s;
   logic                 drop_s;
   logic                 pop_s;
   logic                 start_s;
   logic                 timeout_s;
   logic                 dispatch_s;
   logic                 done_s;
   logic                 timer_clr_s;
   logic                 timer_inc_s;
   logic [TW-1:0]        timer_r;
   logic                 ob_start_r;
   logic                 done_pulse_r;
   logic [2:0]           ob_request_r;
   logic [STOCK_W-1:0]   ob_stock_r;
   logic [ORDER_W-1:0]   ob_order_r;
   logic [QTY_W-1:0]     ob_qty_r;
   logic [OID_W-1:0]     ob_order_id_r;

   assign push_s       = in_valid && in_ready_r;
   assign head_s       = mem_r[rd_ptr_r];
   assign head_req_s   = head_s[ENTRY_W-1 -: 3];
   assign head_stock_s = head_s[OID_W+QTY_W+ORDER_W +: STOCK_W];
   assign head_order_s = head_s[OID_W+QTY_W +: ORDER_W];
   assign head_qty_s   = head_s[OID_W +: QTY_W];
   assign head_oid_s   = head_s[0 +: OID_W];
   assign head_ok_s    = cmd_ok(head_req_s, head_stock_s);
   assign pop_s        = latch_s || drop_s;
   assign done_s       = timeout_s || dispatch_s;

   // FIFO storage: write the packed command at the tail on every accepted push.
   always_ff @(posedge clk_in) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {in_request, in_stock, in_order, in_qty, in_order_id};
      end
   end

   // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
   always_comb begin
      level_next_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_next_s = level_r + LEVEL_ONE;
         2'b01:   level_next_s = level_r - LEVEL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // FIFO pointers, level and the registered ready flag.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= LEVEL_ZERO;
         in_ready_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         level_r    <= level_next_s;
         in_ready_r <= (level_next_s != LEVEL_FULL);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next state: a stale busy in IDLE holds off the next pop.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if ((level_r != LEVEL_ZERO) && !ob_busy && head_ok_s) begin
               state_next_s = ISSUE;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: state_next_s = WAIT_HI;
         WAIT_HI: begin
            if (ob_busy) begin
               state_next_s = WAIT_LO;
            end else if (timer_r == TIMER_LIMIT) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_HI;
            end
         end
         WAIT_LO: begin
            if (!ob_busy) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_LO;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM control strobes; start and done are registered one cycle later.
   always_comb begin
      latch_s     = 1'b0;
      drop_s      = 1'b0;
      start_s     = 1'b0;
      timeout_s   = 1'b0;
      dispatch_s  = 1'b0;
      timer_clr_s = 1'b0;
      timer_inc_s = 1'b0;
      case (state_r)
         IDLE: begin
            if ((level_r != LEVEL_ZERO) && !ob_busy) begin
               latch_s = head_ok_s;
               drop_s  = !head_ok_s;
            end else begin
               latch_s = 1'b0;
               drop_s  = 1'b0;
            end
         end
         ISSUE: begin
            start_s     = 1'b1;
            timer_clr_s = 1'b1;
         end
         WAIT_HI: begin
            if (ob_busy) begin
               timer_inc_s = 1'b0;
            end else if (timer_r == TIMER_LIMIT) begin
               timeout_s = 1'b1;
            end else begin
               timer_inc_s = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!ob_busy) begin
               dispatch_s = 1'b1;
            end else begin
               dispatch_s = 1'b0;
            end
         end
         default: begin
            latch_s = 1'b0;
         end
      endcase
   end

   // Busy-rise timer, cleared on issue and counted while waiting for busy.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         timer_r <= {TW{1'b0}};
      end else if (timer_clr_s) begin
         timer_r <= {TW{1'b0}};
      end else if (timer_inc_s) begin
         timer_r <= timer_r + TIMER_ONE;
      end
   end

   // Registered handshake outputs and the held command fields for the wrapper.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ob_start_r    <= 1'b0;
         done_pulse_r  <= 1'b0;
         ob_request_r  <= 3'd0;
         ob_stock_r    <= {STOCK_W{1'b0}};
         ob_order_r    <= {ORDER_W{1'b0}};
         ob_qty_r      <= {QTY_W{1'b0}};
         ob_order_id_r <= {OID_W{1'b0}};
      end else begin
         ob_start_r   <= start_s;
         done_pulse_r <= done_s;
         if (latch_s) begin
            ob_request_r  <= head_req_s;
            ob_stock_r    <= head_stock_s;
            ob_order_r    <= head_order_s;
            ob_qty_r      <= head_qty_s;
            ob_order_id_r <= head_oid_s;
         end
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [15:0] dispatch_count_r;
   logic [15:0] drop_count_r;
   logic [7:0]  timeout_count_r;

   // Saturating event counters.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         dispatch_count_r <= 16'd0;
         drop_count_r     <= 16'd0;
         timeout_count_r  <= 8'd0;
      end else begin
         if (dispatch_s && (dispatch_count_r != 16'hFFFF)) begin
            dispatch_count_r <= dispatch_count_r + 16'd1;
         end
         if (drop_s && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
         end
         if (timeout_s && (timeout_count_r != 8'hFF)) begin
            timeout_count_r <= timeout_count_r + 8'd1;
         end
      end
   end

   assign dispatch_count = dispatch_count_r;
   assign drop_count     = drop_count_r;
   assign timeout_count  = timeout_count_r;
`else
   assign dispatch_count = 16'd0;
   assign drop_count     = 16'd0;
   assign timeout_count  = 8'd0;
`endif

   assign in_ready    = in_ready_r;
   assign fifo_level  = level_r;
   assign ob_start    = ob_start_r;
   assign done_pulse  = done_pulse_r;
   assign ob_request  = ob_request_r;
   assign ob_stock    = ob_stock_r;
   assign ob_order    = ob_order_r;
   assign ob_qty      = ob_qty_r;
   assign ob_order_id = ob_order_id_r;

endmodule

// File: tb/tb_order_dispatcher.sv
// Directed bench for order_dispatcher: latency, burst/backpressure, drops,
// busy timeout and mid-command reset. Counter expectations follow the build.
module tb_order_dispatcher;

`ifdef DISPATCH_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_request = 3'd0;
   logic [1:0]  in_stock = 2'd0;
   logic [31:0] in_order = 32'd0;
   logic [7:0]  in_qty = 8'd0;
   logic [7:0]  in_order_id = 8'd0;
   logic        ob_start;
   logic [2:0]  ob_request;
   logic [1:0]  ob_stock;
   logic [31:0] ob_order;
   logic [7:0]  ob_qty;
   logic [7:0]  ob_order_id;
   logic        ob_busy = 1'b0;
   logic        done_pulse;
   logic [3:0]  fifo_level;
   logic [15:0] dispatch_count;
   logic [15:0] drop_count;
   logic [7:0]  timeout_count;

   int checks = 0;
   int passed = 0;
   int start_seen = 0;
   int done_seen = 0;
   int ready_bad = 0;
   bit saw_full = 1'b0;

   logic [2:0]  got_req   [0:31];
   logic [1:0]  got_stock [0:31];
   logic [31:0] got_order [0:31];
   logic [7:0]  got_qty   [0:31];
   logic [7:0]  got_id    [0:31];
   int          rec_n = 0;

   order_dispatcher dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_request(in_request),
      .in_stock(in_stock), .in_order(in_order), .in_qty(in_qty),
      .in_order_id(in_order_id),
      .ob_start(ob_start), .ob_request(ob_request), .ob_stock(ob_stock),
      .ob_order(ob_order), .ob_qty(ob_qty), .ob_order_id(ob_order_id),
      .ob_busy(ob_busy), .done_pulse(done_pulse), .fifo_level(fifo_level),
      .dispatch_count(dispatch_count), .drop_count(drop_count),
      .timeout_count(timeout_count)
   );

   always #5 clk_in = ~clk_in;

   // Passive monitor: pulse counts and in_ready/level consistency.
   always @(negedge clk_in) begin
      if (ob_start === 1'b1) start_seen <= start_seen + 1;
      if (done_pulse === 1'b1) done_seen <= done_seen + 1;
      if (rst_in === 1'b1) begin
         if (fifo_level == 4'd8 && in_ready === 1'b0) saw_full <= 1'b1;
         if (in_ready !== (fifo_level != 4'd8)) ready_bad <= ready_bad + 1;
      end
   end

   task automatic push_cmd(input logic [2:0] req, input logic [1:0] stk,
                           input logic [31:0] ord, input logic [7:0] qty,
                           input logic [7:0] oid);
      bit acc;
      acc = 1'b0;
      in_request = req; in_stock = stk; in_order = ord; in_qty = qty; in_order_id = oid;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && !acc; k++) begin
         acc = in_ready;
         @(negedge clk_in);
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         $display("FAIL push_accept: in_ready never seen for order %h", ord);
      end
   endtask

   task automatic wait_start(output bit found);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         if (ob_start === 1'b1) found = 1'b1;
         else @(negedge clk_in);
      end
      checks++;
      if (found) passed++;
      else $display("FAIL wait_start: ob_start=0 after 300 cycles, required 1");
   endtask

   // Wrapper model: busy rises 1 cycle after start and stays up 'hold' cycles.
   task automatic serve(input int n, input int hold);
      bit found;
      bit seen;
      for (int i = 0; i < n; i++) begin
         wait_start(found);
         if (!found) return;
         got_req[rec_n] = ob_request; got_stock[rec_n] = ob_stock;
         got_order[rec_n] = ob_order; got_qty[rec_n] = ob_qty; got_id[rec_n] = ob_order_id;
         rec_n++;
         @(negedge clk_in); ob_busy = 1'b1;
         repeat (hold - 1) @(negedge clk_in);
         @(negedge clk_in); ob_busy = 1'b0;
         seen = 1'b0;
         for (int k = 0; k < 20 && !seen; k++) begin
            if (done_pulse === 1'b1) seen = 1'b1;
            else @(negedge clk_in);
         end
         checks++;
         if (seen) passed++;
         else $display("FAIL serve_done: done_pulse=0 after busy fell, required 1 (cmd %0d)", i);
      end
   endtask

   task automatic test_reset;
      rst_in = 1'b0;
      repeat (2) @(negedge clk_in);
      checks++;
      if ({in_ready, ob_start, done_pulse, fifo_level} !== 7'd0) begin
         $display("FAIL reset_ctrl: ready/start/done/level=%b/%b/%b/%0d required 0/0/0/0",
                  in_ready, ob_start, done_pulse, fifo_level);
      end else passed++;
      checks++;
      if ({ob_request, ob_stock, ob_order, ob_qty, ob_order_id} !== 53'd0 ||
          {dispatch_count, drop_count, timeout_count} !== 40'd0) begin
         $display("FAIL reset_fields: ob_order=%h counters=%0d/%0d/%0d required all 0",
                  ob_order, dispatch_count, drop_count, timeout_count);
      end else passed++;
      #1 rst_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (in_ready !== 1'b1 || fifo_level !== 4'd0) begin
         $display("FAIL reset_release: in_ready=%b level=%0d required 1/0", in_ready, fifo_level);
      end else passed++;
   endtask

   task automatic test_single_add;
      in_request = 3'd1; in_stock = 2'd1; in_order = 32'h12345678;
      in_qty = 8'd0; in_order_id = 8'd0; in_valid = 1'b1;
      @(negedge clk_in);                    // after E0
      in_valid = 1'b0;
      checks++;
      if (ob_start !== 1'b0 || fifo_level !== 4'd1) begin
         $display("FAIL single_e0: start=%b level=%0d required 0/1", ob_start, fifo_level);
      end else passed++;
      @(negedge clk_in);                    // after E1
      checks++;
      if (ob_start !== 1'b0 || fifo_level !== 4'd0) begin
         $display("FAIL single_e1: start=%b level=%0d required 0/0", ob_start, fifo_level);
      end else passed++;
      @(negedge clk_in);                    // after E2
      checks++;
      if (ob_start !== 1'b1 || ob_order !== 32'h12345678 || ob_stock !== 2'd1 || ob_request !== 3'd1) begin
         $display("FAIL single_start: start=%b order=%h stock=%0d req=%0d required 1/12345678/1/1",
                  ob_start, ob_order, ob_stock, ob_request);
      end else passed++;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk_in);
         if (c == 1) ob_busy = 1'b1;
         if (c == 4) ob_busy = 1'b0;
         checks++;
         if (ob_start !== 1'b0 || done_pulse !== 1'b0 || ob_order !== 32'h12345678) begin
            $display("FAIL single_hold: cycle %0d start=%b done=%b order=%h required 0/0/12345678",
                     c, ob_start, done_pulse, ob_order);
         end else passed++;
      end
      @(negedge clk_in);
      checks++;
      if (done_pulse !== 1'b1 || ob_order !== 32'h12345678 || dispatch_count !== 16'(STATS)) begin
         $display("FAIL single_done: done=%b order=%h dispatch=%0d required 1/12345678/%0d",
                  done_pulse, ob_order, dispatch_count, STATS);
      end else passed++;
      @(negedge clk_in);
      checks++;
      if (done_pulse !== 1'b0) begin
         $display("FAIL single_done_width: done=%b required 0", done_pulse);
      end else passed++;
   endtask

   task automatic test_burst;
      int s0, d0;
      logic [31:0] exp_ord;
      logic [2:0]  exp_req;
      s0 = start_seen; d0 = done_seen; rec_n = 0;
      fork
         begin
            for (int i = 0; i < 10; i++)
               push_cmd(3'((i % 3) + 1), 2'(i % 2), 32'h100 + 32'(i), 8'(i), 8'h80 + 8'(i));
         end
         serve(10, 5);
      join
      repeat (3) @(negedge clk_in);
      checks++;
      if (rec_n !== 10) $display("FAIL burst_count: issued %0d required 10", rec_n);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         exp_ord = 32'h100 + 32'(i);
         exp_req = 3'((i % 3) + 1);
         checks++;
         if (got_order[i] !== exp_ord || got_req[i] !== exp_req || got_stock[i] !== 2'(i % 2)) begin
            $display("FAIL burst_order: slot %0d order=%h req=%0d stock=%0d required %h/%0d/%0d",
                     i, got_order[i], got_req[i], got_stock[i], exp_ord, exp_req, i % 2);
         end else passed++;
      end
      checks++;
      if (start_seen - s0 !== 10 || done_seen - d0 !== 10) begin
         $display("FAIL burst_pulses: starts=%0d dones=%0d required 10/10", start_seen - s0, done_seen - d0);
      end else passed++;
      checks++;
      if (saw_full !== 1'b1 || ready_bad !== 0) begin
         $display("FAIL burst_ready: saw_full=%b ready_mismatches=%0d required 1/0", saw_full, ready_bad);
      end else passed++;
      checks++;
      if (dispatch_count !== 16'(11 * STATS)) begin
         $display("FAIL burst_dispatch: got %0d required %0d", dispatch_count, 11 * STATS);
      end else passed++;
   endtask

   task automatic test_drops;
      int s0, d0;
      s0 = start_seen; d0 = done_seen; rec_n = 0;
      fork
         begin
            push_cmd(3'd0, 2'd0, 32'hBAD0, 8'd0, 8'd0);
            push_cmd(3'd1, 2'd0, 32'h0000_000A, 8'd0, 8'd0);
            push_cmd(3'd5, 2'd1, 32'hBAD5, 8'd0, 8'd0);
            push_cmd(3'd2, 2'd1, 32'd0, 8'd0, 8'h22);
            push_cmd(3'd1, 2'd2, 32'hBAD2, 8'd0, 8'd0);
         end
         serve(2, 2);
      join
      repeat (4) @(negedge clk_in);
      checks++;
      if (start_seen - s0 !== 2 || done_seen - d0 !== 2) begin
         $display("FAIL drop_pulses: starts=%0d dones=%0d required 2/2", start_seen - s0, done_seen - d0);
      end else passed++;
      checks++;
      if (got_order[0] !== 32'h0000_000A || got_req[1] !== 3'd2 || got_id[1] !== 8'h22 || got_stock[1] !== 2'd1) begin
         $display("FAIL drop_fields: order0=%h req1=%0d id1=%h stock1=%0d required 0000000a/2/22/1",
                  got_order[0], got_req[1], got_id[1], got_stock[1]);
      end else passed++;
      checks++;
      if (drop_count !== 16'(3 * STATS) || dispatch_count !== 16'(13 * STATS) || fifo_level !== 4'd0) begin
         $display("FAIL drop_count: drops=%0d dispatch=%0d level=%0d required %0d/%0d/0",
                  drop_count, dispatch_count, fifo_level, 3 * STATS, 13 * STATS);
      end else passed++;
   endtask

   task automatic test_timeout;
      bit found;
      rec_n = 0;
      fork
         begin
            push_cmd(3'd1, 2'd0, 32'hDEAD_BEEF, 8'd0, 8'd0);
            push_cmd(3'd3, 2'd1, 32'd0, 8'd7, 8'd9);
         end
         wait_start(found);
      join
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_in);
         checks++;
         if (done_pulse !== (c == 5)) begin
            $display("FAIL timeout_done: %0d cycles after start done=%b required %b", c, done_pulse, c == 5);
         end else passed++;
      end
      checks++;
      if (timeout_count !== 8'(STATS) || dispatch_count !== 16'(13 * STATS)) begin
         $display("FAIL timeout_count: timeouts=%0d dispatch=%0d required %0d/%0d",
                  timeout_count, dispatch_count, STATS, 13 * STATS);
      end else passed++;
      serve(1, 1);
      checks++;
      if (rec_n !== 1 || got_req[0] !== 3'd3 || got_qty[0] !== 8'd7 || got_id[0] !== 8'd9 ||
          dispatch_count !== 16'(14 * STATS)) begin
         $display("FAIL timeout_next: n=%0d req=%0d qty=%0d id=%0d dispatch=%0d required 1/3/7/9/%0d",
                  rec_n, got_req[0], got_qty[0], got_id[0], dispatch_count, 14 * STATS);
      end else passed++;
   endtask

   task automatic test_reset_mid;
      bit found;
      int s0;
      fork
         begin
            for (int i = 0; i < 4; i++) push_cmd(3'd1, 2'd0, 32'h40 + 32'(i), 8'd0, 8'd0);
         end
         begin
            wait_start(found);
            @(negedge clk_in); ob_busy = 1'b1;
            repeat (2) @(negedge clk_in);
         end
      join
      checks++;
      if (fifo_level !== 4'd3) $display("FAIL rstmid_level_before: level=%0d required 3", fifo_level);
      else passed++;
      #1 rst_in = 1'b0;
      #1;
      checks++;
      if (ob_start !== 1'b0 || fifo_level !== 4'd0 || in_ready !== 1'b0 || ob_order !== 32'd0 ||
          dispatch_count !== 16'd0) begin
         $display("FAIL rstmid_async: start=%b level=%0d ready=%b order=%h dispatch=%0d required 0/0/0/0/0",
                  ob_start, fifo_level, in_ready, ob_order, dispatch_count);
      end else passed++;
      ob_busy = 1'b0;
      @(negedge clk_in);
      #1 rst_in = 1'b1;
      @(negedge clk_in);
      s0 = start_seen;
      checks++;
      if (in_ready !== 1'b1 || fifo_level !== 4'd0) begin
         $display("FAIL rstmid_release: ready=%b level=%0d required 1/0", in_ready, fifo_level);
      end else passed++;
      repeat (6) @(negedge clk_in);
      checks++;
      if (start_seen !== s0 || done_pulse !== 1'b0 || fifo_level !== 4'd0) begin
         $display("FAIL rstmid_idle: extra starts=%0d done=%b level=%0d required 0/0/0",
                  start_seen - s0, done_pulse, fifo_level);
      end else passed++;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_burst();
      test_drops();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/order_dispatcher.md
Name: order_dispatcher

Overview:
- Upstream stage of the order-book wrapper. Accepts decoded order commands (add/cancel/execute) from the message parser over a valid/ready stream and buffers them in a small FIFO.
- Issues commands to the wrapper one at a time: a one-cycle start pulse with fields held stable, then waits for the wrapper's busy signal to rise and fall before issuing the next command.
- Drops malformed commands and counts dispatches, drops and timeouts.

Parameters:
- STOCK_W, 2: stock index width (matches wrapper stock_to_add).
- NUM_STOCKS, 2: valid stock ids are 0..NUM_STOCKS-1.
- ORDER_W, 32: packed order word width (matches wrapper order_to_add).
- QTY_W, 8: execute quantity width.
- OID_W, 8: order id width.
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- BUSY_TIMEOUT, 4: cycles to wait for busy to rise after start.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: command valid.
- in_ready, output, 1: FIFO can accept.
- in_request, input, 3: 1=ADD, 2=CANCEL, 3=EXECUTE; all other values are invalid.
- in_stock, input, STOCK_W: target stock.
- in_order, input, ORDER_W: order word (ADD).
- in_qty, input, QTY_W: quantity (EXECUTE).
- in_order_id, input, OID_W: id (CANCEL/EXECUTE).
- ob_start, output, 1: one-cycle start to wrapper.
- ob_request, output, 3: held request.
- ob_stock, output, STOCK_W: held stock.
- ob_order, output, ORDER_W: held order.
- ob_qty, output, QTY_W: held quantity.
- ob_order_id, output, OID_W: held id.
- ob_busy, input, 1: wrapper is_busy.
- done_pulse, output, 1: one cycle when a command completes or times out.
- fifo_level, output, log2(DEPTH)+1: occupancy.
- dispatch_count, output, 16: completed commands.
- drop_count, output, 16: rejected commands.
- timeout_count, output, 8: busy-timeouts.

Behaviour:
- Reset (rst_in=0, async):
  - FIFO emptied, FSM to IDLE.
  - Outputs: ob_start=0, done_pulse=0, in_ready=0, all ob_* fields=0, all counters=0.
  - On release, in_ready=1 from the first clock edge.
  - A reset mid-command abandons that command and all queued commands.
- Input handshake:
  - A command is accepted at a rising edge with in_valid&in_ready.
  - in_ready = (fifo_level != DEPTH).
  - A push and a pop in the same cycle are both honoured; level is unchanged.
- Validation at pop:
  - A command with in_request not in {1,2,3} or in_stock >= NUM_STOCKS is discarded.
  - Discard increments drop_count (saturating at 0xFFFF), issues no start, asserts no done_pulse, and takes 1 cycle in IDLE.
- FSM:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Valid head: latch it into ob_*, assert ob_start next cycle, go to ISSUE.
    - Invalid head: drop as above and stay in IDLE.
  - ISSUE: ob_start=1 for exactly this cycle. Go to WAIT_HI and clear the timer.
  - WAIT_HI:
    - ob_busy=1: go to WAIT_LO.
    - Otherwise increment the timer. When the timer reaches BUSY_TIMEOUT: done_pulse, timeout_count++ (saturating), go to IDLE.
  - WAIT_LO: when ob_busy=0, done_pulse=1, dispatch_count++ (saturating), go to IDLE.
- ob_* fields hold their value from ISSUE until the next latch. They never change while the wrapper may sample them.
- Latency, with FSM idle and FIFO empty:
  - Command accepted at edge E0.
  - ob_start is high in the cycle after edge E2.
- Back-to-back commands: a minimum of 1 IDLE cycle between done_pulse and the next ob_start.
- ob_busy high while in IDLE (a stale wrapper op) blocks issue until it is low.
- fifo_level is the registered occupancy and updates at the same edge as push/pop.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- Defined: dispatch_count, drop_count and timeout_count operate as above.
- Undefined: the counter registers are not built and those outputs are tied to 0. Drop and timeout behaviour (discard, FSM transitions, done_pulse) are unchanged.

Test Plan:
- Single ADD, stock 1, order 0x12345678, idle DUT; wrapper model raises busy 1 cycle after start and holds it 3 cycles -> ob_start is one cycle at latency 2, ob_order=0x12345678 stable until done_pulse, dispatch_count=1.
- Burst of 10 commands with busy held 5 cycles each, DEPTH=8 -> in_ready drops when the level reaches 8; all 10 issued in order; 10 done_pulses; no loss or duplication.
- Commands with request=0, request=5 and stock=2 (NUM_STOCKS=2) interleaved with 2 valid commands -> drop_count=3, exactly 2 ob_start pulses, 2 done_pulses.
- Busy never asserted after start -> done_pulse 5 cycles after ob_start (BUSY_TIMEOUT=4), timeout_count=1, next queued command proceeds.
- Assert rst_in low during WAIT_LO with 3 entries queued -> ob_start=0 and fifo_level=0 immediately; after release the FSM is in IDLE and in_ready=1.
- Build without DISPATCH_STATS_EN and repeat the first and third scenarios -> all counters read 0; start/done behaviour is identical.
